// File: rtl/sht40_meas_scheduler.sv
// SHT40 measurement scheduler: periodic/one-shot measure command, conversion wait, 6-byte read, retry on NACK.
// Define SHT40_CRC_CHECK_EN to verify the sensor CRC-8 bytes; otherwise CHECK always passes.
module sht40_meas_scheduler #(
    parameter int         PERIOD_CYCLES = 1000,
    parameter int         CONV_CYCLES   = 200,
    parameter logic [6:0] SENSOR_ADDR   = 7'h44,
    parameter logic [7:0] MEAS_CMD      = 8'hFD,
    parameter int         MAX_RETRY     = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Enable,
    input  logic        Trigger,
    output logic        Cmd_Valid,
    output logic        Cmd_Rw,
    output logic [6:0]  Cmd_Address,
    output logic [7:0]  Cmd_Byte,
    output logic [2:0]  Cmd_Len,
    input  logic        Cmd_Ready,
    input  logic        Rx_Valid,
    input  logic [7:0]  Rx_Byte,
    input  logic        Txn_Done,
    input  logic        Txn_Nack,
    output logic [15:0] Temperature_Output,
    output logic [15:0] Humidity_Output,
    output logic        Meas_Valid,
    output logic        CRC_Error,
    output logic        Nack_Error,
    output logic        Busy,
    output logic [3:0]  State_Out
);

    localparam int PW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam int CW = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam logic [PW-1:0] PERIOD_LAST = PW'(PERIOD_CYCLES - 1);
    localparam logic [CW-1:0] CONV_LAST   = CW'(CONV_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        SEND_CMD  = 4'd1,
        WAIT_CMD  = 4'd2,
        CONVERT   = 4'd3,
        SEND_READ = 4'd4,
        RX        = 4'd5,
        CHECK     = 4'd6,
        BACKOFF   = 4'd7
    } state_t;

    state_t        state_reg;
    logic [PW-1:0] period_cnt_reg;
    logic [CW-1:0] conv_cnt_reg;
    logic [RW-1:0] retry_reg;
    logic [2:0]    rx_cnt_reg;
    logic [7:0]    rx_buf_reg [0:5];

    logic          rx_store;
    logic [2:0]    rx_total;

    assign rx_store  = Rx_Valid && (rx_cnt_reg < 3'd6);
    assign rx_total  = rx_cnt_reg + {2'b00, rx_store};
    assign Busy      = (state_reg != IDLE);
    assign State_Out = state_reg;

`ifdef SHT40_CRC_CHECK_EN
    logic crc_err_reg;
    logic crc_ok;

    function automatic logic [7:0] crc8_pair(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] crc;
        crc = 8'hFF ^ a;
        for (int i = 0; i < 8; i++)
            crc = crc[7] ? ((crc << 1) ^ 8'h31) : (crc << 1);
        crc = crc ^ b;
        for (int i = 0; i < 8; i++)
            crc = crc[7] ? ((crc << 1) ^ 8'h31) : (crc << 1);
        return crc;
    endfunction

    assign crc_ok    = (crc8_pair(rx_buf_reg[0], rx_buf_reg[1]) == rx_buf_reg[2]) &&
                       (crc8_pair(rx_buf_reg[3], rx_buf_reg[4]) == rx_buf_reg[5]);
    assign CRC_Error = crc_err_reg;
`else
    assign CRC_Error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg          <= IDLE;
            period_cnt_reg     <= '0;
            conv_cnt_reg       <= '0;
            retry_reg          <= '0;
            rx_cnt_reg         <= '0;
            for (int i = 0; i < 6; i++) rx_buf_reg[i] <= 8'h00;
            Cmd_Valid          <= 1'b0;
            Cmd_Rw             <= 1'b0;
            Cmd_Address        <= 7'h00;
            Cmd_Byte           <= 8'h00;
            Cmd_Len            <= 3'd0;
            Temperature_Output <= 16'h0000;
            Humidity_Output    <= 16'h0000;
            Meas_Valid         <= 1'b0;
            Nack_Error         <= 1'b0;
`ifdef SHT40_CRC_CHECK_EN
            crc_err_reg        <= 1'b0;
`endif
        end else begin
            Meas_Valid <= 1'b0;
`ifdef SHT40_CRC_CHECK_EN
            crc_err_reg <= 1'b0;
`endif
            case (state_reg)
                IDLE: begin
                    // A coinciding Trigger and period expiry fall into the same single start.
                    if (Trigger || (Enable && period_cnt_reg == PERIOD_LAST)) begin
                        period_cnt_reg <= '0;
                        state_reg      <= SEND_CMD;
                        Cmd_Valid      <= 1'b1;
                        Cmd_Rw         <= 1'b0;
                        Cmd_Address    <= SENSOR_ADDR;
                        Cmd_Byte       <= MEAS_CMD;
                        Cmd_Len        <= 3'd0;
                    end else if (Enable) begin
                        period_cnt_reg <= period_cnt_reg + 1'b1;
                    end else begin
                        period_cnt_reg <= '0;
                    end
                end
                SEND_CMD: begin
                    if (Cmd_Ready) begin
                        Cmd_Valid <= 1'b0;
                        state_reg <= WAIT_CMD;
                    end
                end
                WAIT_CMD: begin
                    if (Txn_Done) begin
                        conv_cnt_reg <= '0;
                        if (Txn_Nack) begin
                            retry_reg <= retry_reg + 1'b1;
                            state_reg <= BACKOFF;
                        end else begin
                            state_reg <= CONVERT;
                        end
                    end
                end
                CONVERT: begin
                    if (conv_cnt_reg == CONV_LAST) begin
                        conv_cnt_reg <= '0;
                        state_reg    <= SEND_READ;
                        Cmd_Valid    <= 1'b1;
                        Cmd_Rw       <= 1'b1;
                        Cmd_Address  <= SENSOR_ADDR;
                        Cmd_Byte     <= 8'h00;
                        Cmd_Len      <= 3'd6;
                    end else begin
                        conv_cnt_reg <= conv_cnt_reg + 1'b1;
                    end
                end
                SEND_READ: begin
                    if (Cmd_Ready) begin
                        Cmd_Valid  <= 1'b0;
                        rx_cnt_reg <= '0;
                        state_reg  <= RX;
                    end
                end
                RX: begin
                    if (rx_store) begin
                        rx_buf_reg[rx_cnt_reg] <= Rx_Byte;
                        rx_cnt_reg             <= rx_total;
                    end
                    if (Txn_Done) begin
                        if (Txn_Nack || rx_total != 3'd6) begin
                            conv_cnt_reg <= '0;
                            retry_reg    <= retry_reg + 1'b1;
                            state_reg    <= BACKOFF;
                        end else begin
                            state_reg <= CHECK;
                        end
                    end
                end
                CHECK: begin
`ifdef SHT40_CRC_CHECK_EN
                    if (crc_ok) begin
                        Temperature_Output <= {rx_buf_reg[0], rx_buf_reg[1]};
                        Humidity_Output    <= {rx_buf_reg[3], rx_buf_reg[4]};
                        Meas_Valid         <= 1'b1;
                        Nack_Error         <= 1'b0;
                    end else begin
                        crc_err_reg <= 1'b1;
                    end
`else
                    Temperature_Output <= {rx_buf_reg[0], rx_buf_reg[1]};
                    Humidity_Output    <= {rx_buf_reg[3], rx_buf_reg[4]};
                    Meas_Valid         <= 1'b1;
                    Nack_Error         <= 1'b0;
`endif
                    // A finished measurement, good or bad, starts the next one with a fresh retry budget.
                    retry_reg <= '0;
                    state_reg <= IDLE;
                end
                BACKOFF: begin
                    if (retry_reg >= RETRY_LIMIT) begin
                        Nack_Error <= 1'b1;
                        retry_reg  <= '0;
                        state_reg  <= IDLE;
                    end else if (conv_cnt_reg == CONV_LAST) begin
                        conv_cnt_reg <= '0;
                        state_reg    <= SEND_CMD;
                        Cmd_Valid    <= 1'b1;
                        Cmd_Rw       <= 1'b0;
                        Cmd_Address  <= SENSOR_ADDR;
                        Cmd_Byte     <= MEAS_CMD;
                        Cmd_Len      <= 3'd0;
                    end else begin
                        conv_cnt_reg <= conv_cnt_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sht40_meas_scheduler.sv
// Scoreboard bench for sht40_meas_scheduler: a scripted I2C master answers requests and
// expected measurement results are queued when read data is driven, then popped on Meas_Valid/CRC_Error.
module tb_sht40_meas_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Enable = 1'b0;
    logic        Trigger = 1'b0;
    logic        Cmd_Ready = 1'b0;
    logic        Rx_Valid = 1'b0;
    logic [7:0]  Rx_Byte = 8'h00;
    logic        Txn_Done = 1'b0;
    logic        Txn_Nack = 1'b0;
    logic        Cmd_Valid, Cmd_Rw;
    logic [6:0]  Cmd_Address;
    logic [7:0]  Cmd_Byte;
    logic [2:0]  Cmd_Len;
    logic [15:0] Temperature_Output, Humidity_Output;
    logic        Meas_Valid, CRC_Error, Nack_Error, Busy;
    logic [3:0]  State_Out;

    sht40_meas_scheduler dut (
        .clk(clk), .rst_n(rst_n), .Enable(Enable), .Trigger(Trigger),
        .Cmd_Valid(Cmd_Valid), .Cmd_Rw(Cmd_Rw), .Cmd_Address(Cmd_Address),
        .Cmd_Byte(Cmd_Byte), .Cmd_Len(Cmd_Len), .Cmd_Ready(Cmd_Ready),
        .Rx_Valid(Rx_Valid), .Rx_Byte(Rx_Byte), .Txn_Done(Txn_Done), .Txn_Nack(Txn_Nack),
        .Temperature_Output(Temperature_Output), .Humidity_Output(Humidity_Output),
        .Meas_Valid(Meas_Valid), .CRC_Error(CRC_Error), .Nack_Error(Nack_Error),
        .Busy(Busy), .State_Out(State_Out)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int handshakes = 0;

    typedef struct {
        bit          crc_fail;
        logic [15:0] t;
        logic [15:0] h;
    } exp_t;
    exp_t sb[$];
    logic [15:0] model_t = 16'h0000;
    logic [15:0] model_h = 16'h0000;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    function automatic logic [7:0] crc8(input logic [15:0] d);
        logic [7:0] c;
        logic       fb;
        c = 8'hFF;
        for (int i = 15; i >= 0; i--) begin
            fb = c[7] ^ d[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h31 : 8'h00);
        end
        return c;
    endfunction

    // Bytes packed MSB-first: b0 in [47:40] .. b5 in [7:0].
    task automatic push_expect(input logic [47:0] b);
        exp_t e;
        bit   bad;
        bad = 1'b0;
`ifdef SHT40_CRC_CHECK_EN
        bad = (crc8(b[47:32]) != b[31:24]) || (crc8(b[23:8]) != b[7:0]);
`endif
        if (!bad) begin
            model_t = b[47:32];
            model_h = b[23:8];
        end
        e.crc_fail = bad;
        e.t = model_t;
        e.h = model_h;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (Meas_Valid || CRC_Error) begin
            if (sb.size() == 0) begin
                check_value("unexpected_pulse", {30'd0, Meas_Valid, CRC_Error}, 32'd0);
            end else begin
                e = sb.pop_front();
                check_value("pulse_kind", {30'd0, Meas_Valid, CRC_Error}, e.crc_fail ? 32'd1 : 32'd2);
                check_value("temperature", {16'd0, Temperature_Output}, {16'd0, e.t});
                check_value("humidity", {16'd0, Humidity_Output}, {16'd0, e.h});
            end
        end
    end

    task automatic wait_cmd(input string tag, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (Cmd_Valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check_value({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic do_handshake(input string tag, input bit rw, input int delay);
        bit          ok;
        bit          stable;
        logic [18:0] exp_f;
        stable = 1'b1;
        exp_f  = {rw, 7'h44, rw ? 8'h00 : 8'hFD, rw ? 3'd6 : 3'd0};
        wait_cmd(tag, 3000, ok);
        if (!ok) return;
        check_value({tag, "_fields"}, {13'd0, Cmd_Rw, Cmd_Address, Cmd_Byte, Cmd_Len}, {13'd0, exp_f});
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            if (Cmd_Valid !== 1'b1 || {Cmd_Rw, Cmd_Address, Cmd_Byte, Cmd_Len} !== exp_f) stable = 1'b0;
        end
        if (delay > 0) check_value({tag, "_stable"}, {31'd0, stable}, 32'd1);
        Cmd_Ready = 1'b1;
        @(negedge clk);
        Cmd_Ready = 1'b0;
        handshakes++;
        check_value({tag, "_valid_drop"}, {31'd0, Cmd_Valid}, 32'd0);
    endtask

    task automatic end_txn(input bit nack);
        repeat (2) @(negedge clk);
        Txn_Done = 1'b1;
        Txn_Nack = nack;
        @(negedge clk);
        Txn_Done = 1'b0;
        Txn_Nack = 1'b0;
    endtask

    task automatic send_bytes(input logic [47:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            Rx_Valid = 1'b1;
            Rx_Byte  = b[47 - 8*i -: 8];
            @(negedge clk);
        end
        Rx_Valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int i;
        i = 0;
        while (State_Out !== 4'd0 && i < 3000) begin
            @(negedge clk);
            i++;
        end
        if (State_Out !== 4'd0) check_value({tag, "_idle_timeout"}, {28'd0, State_Out}, 32'd0);
    endtask

    task automatic measurement(input string tag, input logic [47:0] b, input int delay);
        do_handshake({tag, "_wr"}, 1'b0, delay);
        end_txn(1'b0);
        do_handshake({tag, "_rd"}, 1'b1, delay);
        send_bytes(b, 6);
        push_expect(b);
        end_txn(1'b0);
        wait_idle(tag);
    endtask

    task automatic pulse_trigger();
        Trigger = 1'b1;
        @(negedge clk);
        Trigger = 1'b0;
    endtask

    task automatic count_starts(input int cycles, output int seen);
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (Cmd_Valid === 1'b1) seen++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_value({tag, "_state"}, {28'd0, State_Out}, 32'd0);
        check_value({tag, "_busy"}, {31'd0, Busy}, 32'd0);
        check_value({tag, "_cmd"}, {13'd0, Cmd_Valid, Cmd_Rw, Cmd_Address, Cmd_Byte, Cmd_Len}, 32'd0);
        check_value({tag, "_data"}, {Temperature_Output, Humidity_Output}, 32'd0);
        check_value({tag, "_flags"}, {29'd0, Meas_Valid, CRC_Error, Nack_Error}, 32'd0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin : main
        int          n;
        int          hs0;
        int          seen;
        logic [47:0] b;

        repeat (3) @(negedge clk);
        check_reset_outputs("rst0");
        rst_n  = 1'b1;
        Enable = 1'b1;

        // Periodic measurement, then the gap from IDLE entry to the next start.
        measurement("per", 48'hBEEF92666693, 0);
        n = 0;
        while (Cmd_Valid !== 1'b1 && n < 1100) begin
            @(negedge clk);
            n++;
        end
        check_value("period_gap", n, 32'd1000);

        // Bad temperature CRC; Enable drops mid-measurement and it still completes.
        Enable = 1'b0;
        measurement("crc", 48'hBEEF00666693, 0);

        // Every command write NACKed: three attempts then Nack_Error.
        hs0 = handshakes;
        pulse_trigger();
        for (int k = 0; k < 3; k++) begin
            do_handshake("nack_wr", 1'b0, 0);
            end_txn(1'b1);
        end
        wait_idle("nack");
        check_value("nack_handshakes", handshakes - hs0, 32'd3);
        check_value("nack_error", {31'd0, Nack_Error}, 32'd1);
        check_value("nack_state", {28'd0, State_Out}, 32'd0);
        count_starts(600, seen);
        check_value("nack_no_extra", seen, 32'd0);

        // One-shot with a second Trigger during CONVERT and slow Cmd_Ready.
        hs0 = handshakes;
        b   = {8'h12, 8'h34, crc8(16'h1234), 8'h56, 8'h78, crc8(16'h5678)};
        pulse_trigger();
        do_handshake("os_wr", 1'b0, 5);
        end_txn(1'b0);
        repeat (10) @(negedge clk);
        check_value("os_convert", {28'd0, State_Out}, 32'd3);
        pulse_trigger();
        do_handshake("os_rd", 1'b1, 5);
        send_bytes(b, 6);
        push_expect(b);
        end_txn(1'b0);
        wait_idle("os");
        check_value("os_nack_cleared", {31'd0, Nack_Error}, 32'd0);
        count_starts(600, seen);
        check_value("os_no_extra", seen, 32'd0);
        check_value("os_handshakes", handshakes - hs0, 32'd2);

        // Reset after three received bytes.
        pulse_trigger();
        do_handshake("rst_wr", 1'b0, 0);
        end_txn(1'b0);
        do_handshake("rst_rd", 1'b1, 0);
        send_bytes(48'hBEEF92666693, 3);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_mid");
        rst_n   = 1'b1;
        model_t = 16'h0000;
        model_h = 16'h0000;
        repeat (20) @(negedge clk);
        check_value("rst_after_state", {28'd0, State_Out}, 32'd0);
        check_value("sb_empty", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sht40_meas_scheduler.md
SHT40_MEAS_SCHEDULER -- requirements
Module: sht40_meas_scheduler

Interface
REQ-001 The block SHALL have parameter PERIOD_CYCLES, default 1000, cycles between automatic measurement starts.
REQ-002 The block SHALL have parameter CONV_CYCLES, default 200, wait from command-write done to read start.
REQ-003 The block SHALL have parameter SENSOR_ADDR, default 7'h44, 7-bit I2C address.
REQ-004 The block SHALL have parameter MEAS_CMD, default 8'hFD, measure command byte.
REQ-005 The block SHALL have parameter MAX_RETRY, default 3, NACK retries per measurement.
REQ-006 The block SHALL have these ports: clk in 1 system clock; rst_n in 1 synchronous active-low reset.
REQ-007 The block SHALL have these inputs: Enable 1 (periodic mode); Trigger 1 (one-shot request).
REQ-008 The block SHALL have these master-request outputs: Cmd_Valid 1; Cmd_Rw 1 (1=read); Cmd_Address 7; Cmd_Byte 8; Cmd_Len 3 (read bytes).
REQ-009 The block SHALL have these master-response inputs: Cmd_Ready 1; Rx_Valid 1; Rx_Byte 8; Txn_Done 1; Txn_Nack 1.
REQ-010 The block SHALL have these result outputs: Temperature_Output 16; Humidity_Output 16; Meas_Valid 1 (pulse); CRC_Error 1 (pulse); Nack_Error 1 (sticky); Busy 1; State_Out 4.

Function
REQ-011 The block SHALL implement these states: IDLE, SEND_CMD, WAIT_CMD, CONVERT, SEND_READ, RX, CHECK, BACKOFF.
REQ-012 In IDLE, the period counter SHALL increment while Enable=1 and SHALL clear while Enable=0; at PERIOD_CYCLES-1, or on Trigger=1, the block SHALL go to SEND_CMD with the counter cleared.
REQ-013 If Trigger and period expiry coincide, the block SHALL start exactly one measurement.
REQ-014 Trigger outside IDLE SHALL be ignored and not queued.
REQ-015 In SEND_CMD, the block SHALL hold Cmd_Valid=1, Cmd_Rw=0, Cmd_Address=SENSOR_ADDR, Cmd_Byte=MEAS_CMD, Cmd_Len=0 until the cycle where Cmd_Valid&Cmd_Ready, then go to WAIT_CMD.
REQ-016 Cmd_* fields SHALL be stable while Cmd_Valid=1 and Cmd_Ready=0.
REQ-017 In WAIT_CMD, on Txn_Done with Txn_Nack=0 the block SHALL go to CONVERT; on Txn_Done with Txn_Nack=1 it SHALL go to BACKOFF.
REQ-018 CONVERT SHALL last exactly CONV_CYCLES cycles, then go to SEND_READ.
REQ-019 SEND_READ SHALL behave as SEND_CMD with Cmd_Rw=1, Cmd_Len=6, Cmd_Byte=0.
REQ-020 In RX, each Rx_Valid SHALL store Rx_Byte into a 6-byte buffer at index 0..5 (T_msb, T_lsb, T_crc, RH_msb, RH_lsb, RH_crc); Rx_Valid beyond index 5 SHALL be dropped.
REQ-021 In RX, Txn_Done with Txn_Nack=1, or Txn_Done with fewer than 6 bytes, SHALL go to BACKOFF; Txn_Done with 6 bytes SHALL go to CHECK.
REQ-022 CHECK SHALL take one cycle; on pass, the block SHALL load Temperature_Output={b0,b1} and Humidity_Output={b3,b4}, pulse Meas_Valid for 1 cycle, clear the retry count, and return to IDLE.
REQ-023 On CRC fail, the block SHALL pulse CRC_Error for 1 cycle, leave the outputs unchanged, and return to IDLE without retry.
REQ-024 In BACKOFF, the block SHALL increment the retry count; if count<MAX_RETRY it SHALL wait CONV_CYCLES then go to SEND_CMD; otherwise it SHALL set Nack_Error, clear the count, and go to IDLE.
REQ-025 Nack_Error SHALL clear only on reset or on the next Meas_Valid.
REQ-026 Busy SHALL be 1 in every state except IDLE.
REQ-027 State_Out SHALL be the state encoding IDLE=0 .. BACKOFF=7.
REQ-028 Deasserting Enable mid-measurement SHALL let the measurement complete.

Reset
REQ-029 When rst_n=0 at a clk edge, the block SHALL enter IDLE and clear all counters, the buffer and the retry count.
REQ-030 Reset SHALL drive Cmd_Valid=0, Cmd_Rw=0, Cmd_Address=0, Cmd_Byte=0, Cmd_Len=0, Temperature_Output=0, Humidity_Output=0, Meas_Valid=0, CRC_Error=0, Nack_Error=0, Busy=0 and State_Out=0.
REQ-031 Reset asserted mid-transaction SHALL abort the transaction immediately, with no pulse outputs.

Configuration
REQ-032 With SHT40_CRC_CHECK_EN defined, CHECK SHALL compute CRC-8 (poly 0x31, init 0xFF, no reflection, no final XOR) over {b0,b1} vs b2 and over {b3,b4} vs b5; either mismatch SHALL be a fail.
REQ-033 Without SHT40_CRC_CHECK_EN, CRC_Error SHALL be tied 0, CHECK SHALL always pass, and the CRC bytes SHALL be ignored.

Verification
REQ-034 The bench SHALL cover: Enable=1, PERIOD_CYCLES=1000, master acks, RX bytes BE EF 92 66 66 93 -> Meas_Valid pulse, Temperature_Output=16'hBEEF, Humidity_Output=16'h6666, next Cmd_Valid 1000 cycles after the prior IDLE entry.
REQ-035 The bench SHALL cover: RX bytes BE EF 00 66 66 93 with SHT40_CRC_CHECK_EN -> CRC_Error pulse, outputs unchanged; without the macro -> Meas_Valid, Temperature_Output=16'hBEEF.
REQ-036 The bench SHALL cover: Txn_Nack=1 on every command write with MAX_RETRY=3 -> exactly 3 SEND_CMD handshakes, then Nack_Error=1 and State_Out=0.
REQ-037 The bench SHALL cover: Enable=0, Trigger pulse in IDLE and again during CONVERT -> exactly one measurement; Cmd_Ready held 0 for 5 cycles -> Cmd_* stable throughout.
REQ-038 The bench SHALL cover: rst_n=0 for 1 cycle during RX after 3 bytes -> all outputs at reset values next cycle, State_Out=0, no Meas_Valid.
